xoshiro_prng_buffered: RTL and testbench

- Parametrised xoshiro-family PRNG, the successor to the fixed 32-bit xoshiro128++ generator.
- Selectable state width: xoshiro128 (32-bit words) or xoshiro256 (64-bit words).
- Selectable scrambler: ++ or **.
- Free-running refill engine keeps a small output FIFO topped up, so the bus-facing peripheral can pop one value per cycle through a valid/ready handshake.
- Seed words are loaded by register writes; any write flushes the buffered output.

---
 rtl/xoshiro_pkg.sv | 31 +++
 rtl/xoshiro_core.sv | 51 +++++
 rtl/xoshiro_prng_buffered.sv | 97 +++++++++
 tb/tb_xoshiro_prng_buffered.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/xoshiro_pkg.sv
// Shared constants and helpers for the xoshiro128/xoshiro256 generator family.
// Index 0 selects the 32-bit word set and index 1 the 64-bit word set.
package xoshiro_pkg;

   localparam int SCR_PP = 0;
   localparam int SCR_SS = 1;

   localparam int unsigned ROT_A [2] = '{7, 23};
   localparam int unsigned SHL_B [2] = '{9, 17};
   localparam int unsigned ROT_C [2] = '{11, 45};

   localparam logic [31:0] SEED0_DEF = 32'h0D1929D2;
   localparam logic [31:0] SEED1_DEF = 32'h491DFB74;
   localparam logic [31:0] SEED2_DEF = 32'h473E5E7D;
   localparam logic [31:0] SEED3_DEF = 32'hD6CA8A07;

   function automatic int unsigned width_idx(input int unsigned w);
      return (w == 64) ? 1 : 0;
   endfunction

   // Rotate within a w-bit word (32 or 64), carried in a 64-bit container.
   function automatic logic [63:0] rotl(input logic [63:0] x, input int unsigned k,
                                        input int unsigned w);
      logic [31:0] lo;
      lo = x[31:0];
      if (w == 64)
         return (x << k) | (x >> (64 - k));
      return {32'h0, (lo << k) | (lo >> (32 - k))};
   endfunction

endpackage

// File: rtl/xoshiro_core.sv
// Combinational xoshiro step: scrambled output of the current state plus the next state.
// Holds no registers; the top level owns the state.
module xoshiro_core import xoshiro_pkg::*; #(
   parameter int WIDTH     = 32,
   parameter int SCRAMBLER = SCR_PP
) (
   input  logic [WIDTH-1:0] s0,
   input  logic [WIDTH-1:0] s1,
   input  logic [WIDTH-1:0] s2,
   input  logic [WIDTH-1:0] s3,
   output logic [WIDTH-1:0] n0,
   output logic [WIDTH-1:0] n1,
   output logic [WIDTH-1:0] n2,
   output logic [WIDTH-1:0] n3,
   output logic [WIDTH-1:0] result
);

   localparam int unsigned WI = width_idx(WIDTH);
   localparam int unsigned A  = ROT_A[WI];
   localparam int unsigned B  = SHL_B[WI];
   localparam int unsigned C  = ROT_C[WI];
   localparam logic [WIDTH-1:0] MUL5 = WIDTH'(5);
   localparam logic [WIDTH-1:0] MUL9 = WIDTH'(9);

   logic [WIDTH-1:0] t, a0, a1, a2, a3, rot;

   always_comb begin
      t  = s1 << B;
      a2 = s2 ^ s0;
      a3 = s3 ^ s1;
      a1 = s1 ^ a2;
      a0 = s0 ^ a3;
      n0 = a0;
      n1 = a1;
      n2 = a2 ^ t;
      n3 = WIDTH'(rotl(64'(a3), C, WIDTH));
   end

   always_comb begin
      rot    = '0;
      result = '0;
      if (SCRAMBLER == SCR_SS) begin
         rot    = WIDTH'(rotl(64'(s1 * MUL5), 7, WIDTH));
         result = rot * MUL9;
      end else begin
         rot    = WIDTH'(rotl(64'(s0 + s3), A, WIDTH));
         result = rot + s0;
      end
   end

endmodule

// File: rtl/xoshiro_prng_buffered.sv
// Buffered xoshiro PRNG: state registers with seed writes, plus an inline output FIFO
// refilled every cycle it has room; any seed write flushes buffered values.
module xoshiro_prng_buffered import xoshiro_pkg::*; #(
   parameter int          WIDTH     = 32,
   parameter int          DEPTH     = 4,
   parameter int          SCRAMBLER = SCR_PP,
   parameter logic [31:0] SEED0     = SEED0_DEF,
   parameter logic [31:0] SEED1     = SEED1_DEF,
   parameter logic [31:0] SEED2     = SEED2_DEF,
   parameter logic [31:0] SEED3     = SEED3_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     write,
   input  logic [1:0]               write_addr,
   input  logic [WIDTH-1:0]         write_data,
   output logic [WIDTH-1:0]         rnd,
   output logic                     rnd_valid,
   input  logic                     rnd_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     seed_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   logic [WIDTH-1:0] s   [4];
   logic [WIDTH-1:0] w_s [4];
   logic [WIDTH-1:0] n0, n1, n2, n3, result;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic             pop, full, gen, state_zero;

   xoshiro_core #(.WIDTH(WIDTH), .SCRAMBLER(SCRAMBLER)) u_core (
      .s0(s[0]), .s1(s[1]), .s2(s[2]), .s3(s[3]),
      .n0(n0), .n1(n1), .n2(n2), .n3(n3),
      .result(result)
   );

   assign rnd_valid = (level != '0);
   assign rnd       = rnd_valid ? mem[rd_ptr] : '0;
   assign pop       = rnd_valid & rnd_ready;
   assign full      = (level == FULL_LVL);
   assign gen       = !write && (!full || pop) && !seed_err;

   // State as it will look after this cycle's write; seed_err is judged on that.
   always_comb begin
      for (int unsigned i = 0; i < 4; i++)
         w_s[i] = (write_addr == 2'(i)) ? write_data : s[i];
      state_zero = ~|(w_s[0] | w_s[1] | w_s[2] | w_s[3]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s[0]     <= WIDTH'(SEED0);
         s[1]     <= WIDTH'(SEED1);
         s[2]     <= WIDTH'(SEED2);
         s[3]     <= WIDTH'(SEED3);
         seed_err <= 1'b0;
      end else if (write) begin
         for (int unsigned i = 0; i < 4; i++)
            s[i] <= w_s[i];
         seed_err <= state_zero;
      end else if (gen) begin
         s[0] <= n0;
         s[1] <= n1;
         s[2] <= n2;
         s[3] <= n3;
      end
   end

   always_ff @(posedge clk) begin
      if (gen)
         mem[wr_ptr] <= result;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (write) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (gen) wr_ptr <= wr_ptr + PW'(1);
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         if (gen && !pop)
            level <= level + LW'(1);
         else if (pop && !gen)
            level <= level - LW'(1);
      end
   end

endmodule

// File: tb/tb_xoshiro_prng_buffered.sv
// Directed self-checking bench for xoshiro_prng_buffered (32-bit ++, 32-bit **, 64-bit ++).
module tb_xoshiro_prng_buffered;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        write = 1'b0;
   logic [1:0]  write_addr = 2'd0;
   logic [63:0] write_data = 64'd0;
   logic        rnd_ready = 1'b0;

   logic [31:0] rnd;
   logic        rnd_valid, seed_err;
   logic [2:0]  level;
   logic [31:0] rnd_ss;
   logic        valid_ss, seed_err_ss;
   logic [2:0]  level_ss;
   logic [63:0] rnd64;
   logic        valid64, seed_err64;
   logic [2:0]  level64;

   int total = 0;
   int bad   = 0;

   logic [31:0] ms0, ms1, ms2, ms3;

   always #5 clk = ~clk;

   xoshiro_prng_buffered #(.WIDTH(32), .DEPTH(4), .SCRAMBLER(0)) dut (
      .clk(clk), .rst(rst), .write(write), .write_addr(write_addr),
      .write_data(write_data[31:0]), .rnd(rnd), .rnd_valid(rnd_valid),
      .rnd_ready(rnd_ready), .level(level), .seed_err(seed_err)
   );

   xoshiro_prng_buffered #(.WIDTH(32), .DEPTH(4), .SCRAMBLER(1)) dut_ss (
      .clk(clk), .rst(rst), .write(write), .write_addr(write_addr),
      .write_data(write_data[31:0]), .rnd(rnd_ss), .rnd_valid(valid_ss),
      .rnd_ready(rnd_ready), .level(level_ss), .seed_err(seed_err_ss)
   );

   xoshiro_prng_buffered #(.WIDTH(64), .DEPTH(4), .SCRAMBLER(0)) dut64 (
      .clk(clk), .rst(rst), .write(write), .write_addr(write_addr),
      .write_data(write_data), .rnd(rnd64), .rnd_valid(valid64),
      .rnd_ready(rnd_ready), .level(level64), .seed_err(seed_err64)
   );

   // Reference xoshiro128++ model
   function automatic logic [31:0] rl(input logic [31:0] x, input int k);
      return (x << k) | (x >> (32 - k));
   endfunction

   task automatic m_seed(input logic [31:0] a, b, c, d);
      ms0 = a; ms1 = b; ms2 = c; ms3 = d;
   endtask

   task automatic m_next(output logic [31:0] r);
      logic [31:0] t;
      r   = rl(ms0 + ms3, 7) + ms0;
      t   = ms1 << 9;
      ms2 = ms2 ^ ms0;
      ms3 = ms3 ^ ms1;
      ms1 = ms1 ^ ms2;
      ms0 = ms0 ^ ms3;
      ms2 = ms2 ^ t;
      ms3 = rl(ms3, 11);
   endtask

   // Called and returns at a falling edge; the write occupies one rising edge.
   task automatic wr(input logic [1:0] a, input logic [63:0] d);
      write = 1'b1; write_addr = a; write_data = d;
      @(negedge clk);
      write = 1'b0;
   endtask

   task automatic seed4(input logic [63:0] a, b, c, d);
      wr(2'd0, a); wr(2'd1, b); wr(2'd2, c); wr(2'd3, d);
   endtask

   task automatic test_reset;
      rst = 1'b1; rnd_ready = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (rnd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", rnd_valid); end
      total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", level); end
      total++; if (rnd !== 32'd0) begin bad++; $display("FAIL reset_rnd: got %h want 0", rnd); end
      total++; if (seed_err !== 1'b0) begin bad++; $display("FAIL reset_seed_err: got %0b want 0", seed_err); end
      total++; if (seed_err_ss !== 1'b0 || seed_err64 !== 1'b0) begin bad++; $display("FAIL reset_seed_err_other: got %0b/%0b want 0/0", seed_err_ss, seed_err64); end
      rst = 1'b0;
      @(negedge clk);
      total++; if (rnd_valid !== 1'b1) begin bad++; $display("FAIL first_valid: got %0b want 1", rnd_valid); end
      total++; if (level !== 3'd1) begin bad++; $display("FAIL first_level: got %0d want 1", level); end
      total++; if (rnd !== 32'hFEF316C3) begin bad++; $display("FAIL first_rnd: got %h want fef316c3", rnd); end
      total++; if (valid_ss !== 1'b1 || valid64 !== 1'b1) begin bad++; $display("FAIL first_valid_other: got %0b/%0b want 1/1", valid_ss, valid64); end
   endtask

   task automatic test_fill;
      logic [31:0] e;
      rnd_ready = 1'b0;
      seed4(64'd1, 64'd2, 64'd3, 64'd4);
      total++; if (level !== 3'd0 || rnd_valid !== 1'b0) begin bad++; $display("FAIL fill_flush: got level=%0d valid=%0b want 0/0", level, rnd_valid); end
      repeat (6) @(negedge clk);
      total++; if (level !== 3'd4) begin bad++; $display("FAIL fill_level: got %0d want 4", level); end
      total++; if (rnd !== 32'd641) begin bad++; $display("FAIL fill_rnd: got %0d want 641", rnd); end
      total++; if (rnd_ss !== 32'd11520) begin bad++; $display("FAIL ss_rnd: got %0d want 11520", rnd_ss); end
      total++; if (rnd64 !== 64'd41943041) begin bad++; $display("FAIL w64_rnd: got %0d want 41943041", rnd64); end
      total++; if (level_ss !== 3'd4 || level64 !== 3'd4) begin bad++; $display("FAIL fill_level_other: got %0d/%0d want 4/4", level_ss, level64); end
      rnd_ready = 1'b1;
      @(negedge clk);
      total++; if (rnd !== 32'd1573767) begin bad++; $display("FAIL pop1_rnd: got %0d want 1573767", rnd); end
      total++; if (level !== 3'd4) begin bad++; $display("FAIL pop1_level: got %0d want 4", level); end
      @(negedge clk);
      rnd_ready = 1'b0;
      m_seed(32'd1, 32'd2, 32'd3, 32'd4);
      m_next(e); m_next(e); m_next(e);
      total++; if (rnd !== e) begin bad++; $display("FAIL pop2_rnd: got %h want %h", rnd, e); end
      total++; if (level !== 3'd4) begin bad++; $display("FAIL pop2_level: got %0d want 4", level); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] e;
      rnd_ready = 1'b0;
      m_seed(32'd1, 32'd2, 32'd3, 32'd4);
      seed4(64'd1, 64'd2, 64'd3, 64'd4);
      rnd_ready = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         m_next(e);
         total++; if (rnd !== e) begin bad++; $display("FAIL stream_rnd[%0d]: got %h want %h", i, rnd, e); end
         total++; if (level !== 3'd1) begin bad++; $display("FAIL stream_level[%0d]: got %0d want 1", i, level); end
      end
      rnd_ready = 1'b0;
   endtask

   task automatic test_seed_err;
      rnd_ready = 1'b0;
      seed4(64'd0, 64'd0, 64'd0, 64'd0);
      total++; if (seed_err !== 1'b1) begin bad++; $display("FAIL zero_seed_err: got %0b want 1", seed_err); end
      total++; if (rnd_valid !== 1'b0) begin bad++; $display("FAIL zero_valid: got %0b want 0", rnd_valid); end
      repeat (3) @(negedge clk);
      total++; if (rnd_valid !== 1'b0 || level !== 3'd0) begin bad++; $display("FAIL zero_hold: got valid=%0b level=%0d want 0/0", rnd_valid, level); end
      total++; if (seed_err !== 1'b1) begin bad++; $display("FAIL zero_hold_err: got %0b want 1", seed_err); end
      wr(2'd0, 64'd1);
      total++; if (seed_err !== 1'b0) begin bad++; $display("FAIL recover_err: got %0b want 0", seed_err); end
      total++; if (rnd_valid !== 1'b0) begin bad++; $display("FAIL recover_valid0: got %0b want 0", rnd_valid); end
      @(negedge clk);
      total++; if (rnd_valid !== 1'b1) begin bad++; $display("FAIL recover_valid1: got %0b want 1", rnd_valid); end
      total++; if (rnd !== 32'd129) begin bad++; $display("FAIL recover_rnd: got %0d want 129", rnd); end
   endtask

   task automatic test_write_pop;
      logic [31:0] e;
      rnd_ready = 1'b0;
      seed4(64'd1, 64'd2, 64'd3, 64'd4);
      repeat (3) @(negedge clk);
      total++; if (level !== 3'd3) begin bad++; $display("FAIL wp_pre_level: got %0d want 3", level); end
      rnd_ready = 1'b1;
      wr(2'd0, 64'd5);
      rnd_ready = 1'b0;
      total++; if (level !== 3'd0 || rnd_valid !== 1'b0) begin bad++; $display("FAIL wp_flush: got level=%0d valid=%0b want 0/0", level, rnd_valid); end
      @(negedge clk);
      m_seed(32'd1, 32'd2, 32'd3, 32'd4);
      m_next(e); m_next(e); m_next(e);
      ms0 = 32'd5;
      m_next(e);
      total++; if (level !== 3'd1) begin bad++; $display("FAIL wp_level: got %0d want 1", level); end
      total++; if (rnd !== e) begin bad++; $display("FAIL wp_rnd: got %h want %h", rnd, e); end
   endtask

   task automatic test_rst_mid;
      rnd_ready = 1'b0;
      seed4(64'd1, 64'd2, 64'd3, 64'd4);
      repeat (2) @(negedge clk);
      total++; if (level !== 3'd2) begin bad++; $display("FAIL mid_pre_level: got %0d want 2", level); end
      #2 rst = 1'b1;
      #1;
      total++; if (rnd_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %0b want 0", rnd_valid); end
      total++; if (level !== 3'd0 || rnd !== 32'd0) begin bad++; $display("FAIL mid_clear: got level=%0d rnd=%h want 0/0", level, rnd); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++; if (rnd_valid !== 1'b1 || level !== 3'd1) begin bad++; $display("FAIL mid_restart: got valid=%0b level=%0d want 1/1", rnd_valid, level); end
      total++; if (rnd !== 32'hFEF316C3) begin bad++; $display("FAIL mid_rnd: got %h want fef316c3", rnd); end
   endtask

   initial begin
      test_reset;
      test_fill;
      test_back_to_back;
      test_seed_err;
      test_write_pop;
      test_rst_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
